// File: rtl/multicycle_control_unit.sv
// Multicycle ARM control unit: main-decoder FSM, ALU decode, NZCV flag register
// and condition gating, with a configurable memory stall count.
module multicycle_control_unit #(
  parameter int MEM_WAIT = 0,
  parameter int ALUCTL_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          Op,
  input  logic [5:0]          Funct,
  input  logic [3:0]          Rd,
  input  logic [3:0]          Cond,
  input  logic [11:0]         Src2,
  input  logic [3:0]          ALUFlags,
  output logic                PCWrite,
  output logic                IRWrite,
  output logic                RegWrite,
  output logic                MemWrite,
  output logic                AdrSrc,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ResultSrc,
  output logic [1:0]          ImmSrc,
  output logic [1:0]          RegSrc,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic                Shift,
  output logic                Illegal
);

  localparam int CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_WAIT);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECR   = 4'd6,
    EXECI   = 4'd7,
    ALUWB   = 4'd8,
    BRANCH  = 4'd9,
    ILLEGAL = 4'd10
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    flags_q, flags_d;

  logic [3:0] cmd;
  logic [2:0] alu_dec;
  logic [2:0] alu_ctl;
  logic       no_write;
  logic       is_cmp;
  logic       s_eff;
  logic [1:0] flag_w;
  logic       mov_shift;
  logic       cond_ex;
  logic       cnt_done;
  logic       unused_src2;

  assign unused_src2 = ^Src2[3:0];
  assign cmd         = Funct[4:1];
  assign is_cmp      = (cmd == 4'b1010);
  assign s_eff       = Funct[0] | is_cmp;
  assign flag_w      = {s_eff, s_eff & ((cmd == 4'b0100) | (cmd == 4'b0010) | is_cmp)};
  assign mov_shift   = (cmd == 4'b1101) && (Src2[11:4] != 8'd0);
  assign cnt_done    = (cnt_q == CNT_LAST);
  assign ImmSrc      = Op;
  assign RegSrc      = {Op == 2'b01, Op == 2'b10};

  always_comb begin
    alu_dec  = 3'b000;
    no_write = 1'b0;
    case (cmd)
      4'b0100: alu_dec = 3'b000;
      4'b0010: alu_dec = 3'b001;
      4'b0000: alu_dec = 3'b010;
      4'b1100: alu_dec = 3'b011;
      4'b0001: alu_dec = 3'b100;
      4'b1010: begin alu_dec = 3'b001; no_write = 1'b1; end
      4'b1101: alu_dec = 3'b000;
      default: no_write = 1'b1;
    endcase
  end

  // flags_q is {N,Z,C,V}
  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = flags_q[2];
      4'b0001: cond_ex = ~flags_q[2];
      4'b0010: cond_ex = flags_q[1];
      4'b0011: cond_ex = ~flags_q[1];
      4'b0100: cond_ex = flags_q[3];
      4'b0101: cond_ex = ~flags_q[3];
      4'b0110: cond_ex = flags_q[0];
      4'b0111: cond_ex = ~flags_q[0];
      4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
      4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
      4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
      4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
      4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    flags_d   = flags_q;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    alu_ctl   = 3'b000;
    Shift     = 1'b0;
    Illegal   = 1'b0;
    case (state_q)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (cnt_done) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = DECODE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b00:   state_d = Funct[5] ? EXECI : EXECR;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = ILLEGAL;
        endcase
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
        if (cnt_done) state_d = MEMWB;
        else          cnt_d   = cnt_q + 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        if (cnt_done) begin
          MemWrite = cond_ex;
          state_d  = FETCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = cond_ex;
        state_d   = FETCH;
      end
      EXECR, EXECI: begin
        ALUSrcB = (state_q == EXECI) ? 2'b01 : 2'b00;
        alu_ctl = alu_dec;
        Shift   = mov_shift;
        if (flag_w[1] & cond_ex) flags_d[3:2] = ALUFlags[3:2];
        if (flag_w[0] & cond_ex) flags_d[1:0] = ALUFlags[1:0];
        state_d = ALUWB;
      end
      ALUWB: begin
        RegWrite = cond_ex & ~no_write;
        if (Rd == 4'd15) PCWrite = cond_ex;
        state_d = FETCH;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = cond_ex;
        state_d   = FETCH;
      end
      ILLEGAL: begin
        Illegal = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    // During reset the outputs look like an idle FETCH with every strobe held off
    if (reset) begin
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      MemWrite  = 1'b0;
      Illegal   = 1'b0;
      Shift     = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b1;
      ALUSrcB   = 2'b10;
      ResultSrc = 2'b10;
      alu_ctl   = 3'b000;
    end
  end

  always_comb begin
    ALUControl      = '0;
    ALUControl[2:0] = alu_ctl;
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: MEM_WAIT=0 (dut0) and MEM_WAIT=2 (dut2)
// instances share inputs; each scenario targets one of them.
module tb_multicycle_control_unit;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
                         S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
                         S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_ILLEGAL = 4'd10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  Op;
  logic [5:0]  Funct;
  logic [3:0]  Rd, Cond, ALUFlags;
  logic [11:0] Src2;

  logic       PCWrite0, IRWrite0, RegWrite0, MemWrite0, AdrSrc0, ALUSrcA0, Shift0, Illegal0;
  logic [1:0] ALUSrcB0, ResultSrc0, ImmSrc0, RegSrc0;
  logic [2:0] ALUControl0;
  logic       PCWrite2, IRWrite2, RegWrite2, MemWrite2, AdrSrc2, ALUSrcA2, Shift2, Illegal2;
  logic [1:0] ALUSrcB2, ResultSrc2, ImmSrc2, RegSrc2;
  logic [2:0] ALUControl2;

  multicycle_control_unit #(.MEM_WAIT(0), .ALUCTL_W(3)) dut0 (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .Cond(Cond), .Src2(Src2),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite0), .IRWrite(IRWrite0), .RegWrite(RegWrite0),
    .MemWrite(MemWrite0), .AdrSrc(AdrSrc0), .ALUSrcA(ALUSrcA0), .ALUSrcB(ALUSrcB0),
    .ResultSrc(ResultSrc0), .ImmSrc(ImmSrc0), .RegSrc(RegSrc0), .ALUControl(ALUControl0),
    .Shift(Shift0), .Illegal(Illegal0));

  multicycle_control_unit #(.MEM_WAIT(2), .ALUCTL_W(3)) dut2 (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .Cond(Cond), .Src2(Src2),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite2), .IRWrite(IRWrite2), .RegWrite(RegWrite2),
    .MemWrite(MemWrite2), .AdrSrc(AdrSrc2), .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2),
    .ResultSrc(ResultSrc2), .ImmSrc(ImmSrc2), .RegSrc(RegSrc2), .ALUControl(ALUControl2),
    .Shift(Shift2), .Illegal(Illegal2));

  // {state, PCWrite, IRWrite, RegWrite, MemWrite, Illegal, Shift, ALUControl}
  logic [12:0] obs0, obs2;
  assign obs0 = {dut0.state_q, PCWrite0, IRWrite0, RegWrite0, MemWrite0, Illegal0, Shift0, ALUControl0};
  assign obs2 = {dut2.state_q, PCWrite2, IRWrite2, RegWrite2, MemWrite2, Illegal2, Shift2, ALUControl2};

  typedef struct {
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic [3:0]  flg;
    logic        sel;
    logic [12:0] v;
    logic [12:0] m;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0]  cur_cond, cur_rd, cur_flg;
  logic [1:0]  cur_op;
  logic [5:0]  cur_funct;
  logic [11:0] cur_src2;

  function automatic void set_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                                    input logic [3:0] r, input logic [11:0] s, input logic [3:0] fl);
    cur_cond = c; cur_op = o; cur_funct = f; cur_rd = r; cur_src2 = s; cur_flg = fl;
  endfunction

  function automatic void add(input logic sel, input logic [3:0] st, input logic [4:0] strb,
                              input logic sh, input logic [2:0] alu, input logic chk_alu,
                              input string tag);
    exp_t e;
    e.cond = cur_cond; e.op = cur_op; e.funct = cur_funct; e.rd = cur_rd;
    e.src2 = cur_src2; e.flg = cur_flg; e.sel = sel;
    e.v = {st, strb, sh, alu};
    e.m = chk_alu ? 13'h1FFF : 13'h1FF8;
    e.tag = $sformatf("%s#%0d", tag, sb.size());
    sb.push_back(e);
  endfunction

  function automatic void add_fetch(input logic sel, input int mw, input string tag);
    for (int i = 0; i <= mw; i++)
      add(sel, S_FETCH, (i == mw) ? 5'b11000 : 5'b00000, 1'b0, 3'b000, 1'b1, tag);
  endfunction

  // {NoWrite, ALUControl} expected for each cmd
  function automatic logic [3:0] alu_model(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return 4'b0_000;
      4'b0010: return 4'b0_001;
      4'b0000: return 4'b0_010;
      4'b1100: return 4'b0_011;
      4'b0001: return 4'b0_100;
      4'b1010: return 4'b1_001;
      4'b1101: return 4'b0_000;
      default: return 4'b1_000;
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; Op = 2'b11; Funct = 6'd0; Rd = 4'd0; Cond = 4'hE; Src2 = 12'd0; ALUFlags = 4'hF;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if ({dut0.state_q, dut2.state_q} !== {S_FETCH, S_FETCH}) begin
      n_bad++; $display("FAIL reset_state: got %h/%h want 0/0", dut0.state_q, dut2.state_q);
    end
    n_cmp++;
    if ({dut0.flags_q, dut2.flags_q} !== 8'h00) begin
      n_bad++; $display("FAIL reset_flags: got %b/%b want 0000/0000", dut0.flags_q, dut2.flags_q);
    end
    n_cmp++;
    if ({PCWrite0, IRWrite0, RegWrite0, MemWrite0, Illegal0} !== 5'b00000) begin
      n_bad++; $display("FAIL reset_strobes: got %b want 00000",
                        {PCWrite0, IRWrite0, RegWrite0, MemWrite0, Illegal0});
    end
    n_cmp++;
    if ({AdrSrc0, ALUSrcA0, ALUSrcB0, ResultSrc0, ALUControl0} !== 9'b0_1_10_10_000) begin
      n_bad++; $display("FAIL reset_fetch_sel: got %b want 011010000",
                        {AdrSrc0, ALUSrcA0, ALUSrcB0, ResultSrc0, ALUControl0});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    exp_t e;
    logic [12:0] o;
    do_reset();
    set_instr(4'hE, 2'b00, 6'b001000, 4'd1, 12'd0, 4'd0);
    add_fetch(0, 0, "add");
    add(0, S_DECODE, 5'b00000, 0, 3'b000, 0, "add");
    add(0, S_EXECR,  5'b00000, 0, 3'b000, 1, "add");
    add(0, S_ALUWB,  5'b00100, 0, 3'b000, 0, "add");
    set_instr(4'hE, 2'b00, 6'b101000, 4'd15, 12'd0, 4'd0);
    add_fetch(0, 0, "addi_pc");
    add(0, S_DECODE, 5'b00000, 0, 3'b000, 0, "addi_pc");
    add(0, S_EXECI,  5'b00000, 0, 3'b000, 1, "addi_pc");
    add(0, S_ALUWB,  5'b10100, 0, 3'b000, 0, "addi_pc");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      Cond = e.cond; Op = e.op; Funct = e.funct; Rd = e.rd; Src2 = e.src2; ALUFlags = e.flg;
      #1; o = e.sel ? obs2 : obs0; n_cmp++;
      if ((o & e.m) !== (e.v & e.m)) begin
        n_bad++; $display("FAIL %s: got %b want %b", e.tag, o & e.m, e.v & e.m);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_alu_decode();
    exp_t e;
    logic [12:0] o;
    logic [3:0]  cmds[9] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001, 4'b1010, 4'b1101, 4'b0111, 4'b1101};
    logic [11:0] srcs[9] = '{12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h010, 12'h0, 12'h00F};
    logic [3:0]  m;
    logic        sh;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      m  = alu_model(cmds[i]);
      sh = (cmds[i] == 4'b1101) && (srcs[i][11:4] != 8'd0);
      set_instr(4'hE, 2'b00, {1'b0, cmds[i], 1'b0}, 4'd2, srcs[i], 4'd0);
      add_fetch(0, 0, "alu");
      add(0, S_DECODE, 5'b00000, 0, 3'b000, 0, "alu");
      add(0, S_EXECR,  5'b00000, sh, m[2:0], 1, $sformatf("alu_cmd%b", cmds[i]));
      add(0, S_ALUWB,  {2'b00, ~m[3], 2'b00}, 0, 3'b000, 0, $sformatf("alu_wb%b", cmds[i]));
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      Cond = e.cond; Op = e.op; Funct = e.funct; Rd = e.rd; Src2 = e.src2; ALUFlags = e.flg;
      #1; o = e.sel ? obs2 : obs0; n_cmp++;
      if ((o & e.m) !== (e.v & e.m)) begin
        n_bad++; $display("FAIL %s: got %b want %b", e.tag, o & e.m, e.v & e.m);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flags_branch();
    exp_t e;
    logic [12:0] o;
    do_reset();
    set_instr(4'hE, 2'b00, 6'b000101, 4'd3, 12'd0, 4'b0100);
    add_fetch(0, 0, "subs");
    add(0, S_DECODE, 5'b00000, 0, 3'b000, 0, "subs");
    add(0, S_EXECR,  5'b00000, 0, 3'b001, 1, "subs");
    add(0, S_ALUWB,  5'b00100, 0, 3'b000, 0, "subs");
    set_instr(4'h0, 2'b10, 6'b000000, 4'd0, 12'd0, 4'b0000);
    add_fetch(0, 0, "beq");
    add(0, S_DECODE, 5'b00000, 0, 3'b000, 0, "beq");
    add(0, S_BRANCH, 5'b10000, 0, 3'b000, 1, "beq");
    set_instr(4'h1, 2'b10, 6'b000000, 4'd0, 12'd0, 4'b0000);
    add_fetch(0, 0, "bne");
    add(0, S_DECODE, 5'b00000, 0, 3'b000, 0, "bne");
    add(0, S_BRANCH, 5'b00000, 0, 3'b000, 1, "bne");
    add_fetch(0, 0, "bne_done");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      Cond = e.cond; Op = e.op; Funct = e.funct; Rd = e.rd; Src2 = e.src2; ALUFlags = e.flg;
      #1; o = e.sel ? obs2 : obs0; n_cmp++;
      if ((o & e.m) !== (e.v & e.m)) begin
        n_bad++; $display("FAIL %s: got %b want %b", e.tag, o & e.m, e.v & e.m);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (dut0.flags_q !== 4'b0100) begin
      n_bad++; $display("FAIL subs_flags: got %b want 0100", dut0.flags_q);
    end
  endtask

  task automatic test_ldr_str_wait();
    exp_t e;
    logic [12:0] o;
    do_reset();
    set_instr(4'hE, 2'b01, 6'b011001, 4'd4, 12'd8, 4'd0);
    add_fetch(1, 2, "ldr");
    add(1, S_DECODE, 5'b00000, 0, 3'b000, 0, "ldr");
    add(1, S_MEMADR, 5'b00000, 0, 3'b000, 1, "ldr");
    for (int i = 0; i < 3; i++) add(1, S_MEMRD, 5'b00000, 0, 3'b000, 0, "ldr");
    add(1, S_MEMWB,  5'b00100, 0, 3'b000, 0, "ldr");
    set_instr(4'hF, 2'b01, 6'b011000, 4'd4, 12'd8, 4'd0);
    add_fetch(1, 2, "str_nv");
    add(1, S_DECODE, 5'b00000, 0, 3'b000, 0, "str_nv");
    add(1, S_MEMADR, 5'b00000, 0, 3'b000, 1, "str_nv");
    for (int i = 0; i < 3; i++) add(1, S_MEMWR, 5'b00000, 0, 3'b000, 0, "str_nv");
    set_instr(4'hE, 2'b01, 6'b011000, 4'd4, 12'd8, 4'd0);
    add_fetch(1, 2, "str_al");
    add(1, S_DECODE, 5'b00000, 0, 3'b000, 0, "str_al");
    add(1, S_MEMADR, 5'b00000, 0, 3'b000, 1, "str_al");
    for (int i = 0; i < 3; i++)
      add(1, S_MEMWR, (i == 2) ? 5'b00010 : 5'b00000, 0, 3'b000, 0, "str_al");
    add(1, S_FETCH, 5'b00000, 0, 3'b000, 1, "str_done");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      Cond = e.cond; Op = e.op; Funct = e.funct; Rd = e.rd; Src2 = e.src2; ALUFlags = e.flg;
      #1; o = e.sel ? obs2 : obs0; n_cmp++;
      if ((o & e.m) !== (e.v & e.m)) begin
        n_bad++; $display("FAIL %s: got %b want %b", e.tag, o & e.m, e.v & e.m);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_cmp_illegal();
    exp_t e;
    logic [12:0] o;
    do_reset();
    set_instr(4'hE, 2'b00, 6'b010100, 4'd5, 12'd0, 4'b1000);
    add_fetch(0, 0, "cmp");
    add(0, S_DECODE, 5'b00000, 0, 3'b000, 0, "cmp");
    add(0, S_EXECR,  5'b00000, 0, 3'b001, 1, "cmp");
    add(0, S_ALUWB,  5'b00000, 0, 3'b000, 0, "cmp");
    set_instr(4'hE, 2'b11, 6'b000000, 4'd0, 12'd0, 4'b0000);
    add_fetch(0, 0, "ill");
    add(0, S_DECODE,  5'b00000, 0, 3'b000, 0, "ill");
    add(0, S_ILLEGAL, 5'b00001, 0, 3'b000, 0, "ill");
    add_fetch(0, 0, "ill_after");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      Cond = e.cond; Op = e.op; Funct = e.funct; Rd = e.rd; Src2 = e.src2; ALUFlags = e.flg;
      #1; o = e.sel ? obs2 : obs0; n_cmp++;
      if ((o & e.m) !== (e.v & e.m)) begin
        n_bad++; $display("FAIL %s: got %b want %b", e.tag, o & e.m, e.v & e.m);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (dut0.flags_q !== 4'b1000) begin
      n_bad++; $display("FAIL cmp_flags: got %b want 1000", dut0.flags_q);
    end
  endtask

  task automatic test_reset_midwr();
    exp_t e;
    logic [12:0] o;
    do_reset();
    set_instr(4'hE, 2'b00, 6'b000101, 4'd3, 12'd0, 4'b1111);
    add_fetch(1, 2, "subs2");
    add(1, S_DECODE, 5'b00000, 0, 3'b000, 0, "subs2");
    add(1, S_EXECR,  5'b00000, 0, 3'b001, 1, "subs2");
    add(1, S_ALUWB,  5'b00100, 0, 3'b000, 0, "subs2");
    set_instr(4'hE, 2'b01, 6'b011000, 4'd4, 12'd8, 4'd0);
    add_fetch(1, 2, "str_rst");
    add(1, S_DECODE, 5'b00000, 0, 3'b000, 0, "str_rst");
    add(1, S_MEMADR, 5'b00000, 0, 3'b000, 1, "str_rst");
    add(1, S_MEMWR,  5'b00000, 0, 3'b000, 0, "str_rst");
    add(1, S_MEMWR,  5'b00000, 0, 3'b000, 0, "str_rst");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      Cond = e.cond; Op = e.op; Funct = e.funct; Rd = e.rd; Src2 = e.src2; ALUFlags = e.flg;
      #1; o = e.sel ? obs2 : obs0; n_cmp++;
      if ((o & e.m) !== (e.v & e.m)) begin
        n_bad++; $display("FAIL %s: got %b want %b", e.tag, o & e.m, e.v & e.m);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (dut2.flags_q !== 4'b1111) begin
      n_bad++; $display("FAIL pre_rst_flags: got %b want 1111", dut2.flags_q);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({PCWrite2, IRWrite2, RegWrite2, MemWrite2, Illegal2} !== 5'b00000) begin
      n_bad++; $display("FAIL rst_memwr_strobes: got %b want 00000",
                        {PCWrite2, IRWrite2, RegWrite2, MemWrite2, Illegal2});
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({dut2.state_q, dut2.flags_q, dut2.cnt_q} !== {S_FETCH, 4'b0000, 2'b00}) begin
      n_bad++; $display("FAIL rst_memwr_after: got st=%h fl=%b cnt=%0d want st=0 fl=0000 cnt=0",
                        dut2.state_q, dut2.flags_q, dut2.cnt_q);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end want end");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_add();
    test_alu_decode();
    test_flags_branch();
    test_ldr_str_wait();
    test_cmp_illegal();
    test_reset_midwr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
